// File: rtl/xdma_burst_collector.sv
// xdma_burst_collector
// Collects the AXI write bursts that make up one expected DMA transfer.
// A descriptor announces the total beat count and the AXI ID; each AW burst
// is checked against it, W beats are passed through to the data stream with
// zero latency, and a B response (OKAY/SLVERR) is returned per burst.
// done_o pulses once the whole transfer has been collected, and err_o
// reports whether any burst of that transfer was malformed.

module xdma_burst_collector #(
    parameter int unsigned DataWidth   = 512,
    parameter int unsigned LenWidth    = 32,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned MaxNumBeats = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // expected-transfer descriptor
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    input  logic [LenWidth-1:0]  desc_len_i,
    input  logic [IdWidth-1:0]   desc_id_i,
    // AW channel
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [7:0]           aw_len_i,
    // W channel
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [DataWidth-1:0] w_data_i,
    input  logic                 w_last_i,
    // collected data stream
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [DataWidth-1:0] data_o,
    // B channel
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    // status
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_AW = 3'd1,
        DATA    = 3'd2,
        RESP    = 3'd3,
        DONE    = 3'd4
    } state_e;

    // The remaining-beat comparison needs to hold both a 9-bit burst size
    // and the full descriptor length without truncation.
    localparam int unsigned CmpWidth = (LenWidth > 32'd9) ? LenWidth : 32'd9;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    state_e               state_r, state_s;
    logic [LenWidth-1:0]  remain_r, remain_s;
    logic [IdWidth-1:0]   exp_id_r, exp_id_s;
    logic [IdWidth-1:0]   bid_r, bid_s;
    logic [8:0]           beat_r, beat_s;
    logic                 burst_err_r, burst_err_s;
    logic                 err_r, err_s;

    logic [8:0]           aw_beats_s;
    logic [CmpWidth-1:0]  aw_beats_ext_s;
    logic [CmpWidth-1:0]  remain_ext_s;
    logic                 aw_bad_s;
    logic                 beat_last_s;
    logic [LenWidth-1:0]  remain_dec_s;

    assign aw_beats_s     = {1'b0, aw_len_i} + 9'd1;
    assign aw_beats_ext_s = CmpWidth'(aw_beats_s);
    assign remain_ext_s   = CmpWidth'(remain_r);
    assign aw_bad_s       = (aw_id_i != exp_id_r)
                          | (32'(aw_beats_s) > 32'(MaxNumBeats))
                          | (aw_beats_ext_s > remain_ext_s);
    assign beat_last_s    = (beat_r == 9'd1);
    // A burst longer than the remaining transfer must not wrap the counter.
    assign remain_dec_s   = (remain_r != {LenWidth{1'b0}}) ? (remain_r - LenWidth'(1))
                                                          : {LenWidth{1'b0}};
    assign err_o          = err_r;

    // State and bookkeeping registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            remain_r    <= {LenWidth{1'b0}};
            exp_id_r    <= {IdWidth{1'b0}};
            bid_r       <= {IdWidth{1'b0}};
            beat_r      <= 9'd0;
            burst_err_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            remain_r    <= remain_s;
            exp_id_r    <= exp_id_s;
            bid_r       <= bid_s;
            beat_r      <= beat_s;
            burst_err_r <= burst_err_s;
            err_r       <= err_s;
        end
    end

    // Next-state, register updates and channel outputs decoded from the state.
    always_comb begin
        state_s      = state_r;
        remain_s     = remain_r;
        exp_id_s     = exp_id_r;
        bid_s        = bid_r;
        beat_s       = beat_r;
        burst_err_s  = burst_err_r;
        err_s        = err_r;
        desc_ready_o = 1'b0;
        aw_ready_o   = 1'b0;
        w_ready_o    = 1'b0;
        data_valid_o = 1'b0;
        data_o       = {DataWidth{1'b0}};
        b_valid_o    = 1'b0;
        b_id_o       = {IdWidth{1'b0}};
        b_resp_o     = RespOkay;
        done_o       = 1'b0;

        case (state_r)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    remain_s = desc_len_i;
                    exp_id_s = desc_id_i;
                    err_s    = 1'b0;
                    if (desc_len_i == {LenWidth{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = WAIT_AW;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_AW: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) begin
                    beat_s      = aw_beats_s;
                    bid_s       = aw_id_i;
                    burst_err_s = aw_bad_s;
                    state_s     = DATA;
                end else begin
                    state_s = WAIT_AW;
                end
            end
            DATA: begin
                // Zero-latency pass-through: W stalls exactly when the sink does.
                data_valid_o = w_valid_i;
                w_ready_o    = data_ready_i;
                data_o       = w_data_i;
                if (w_valid_i && data_ready_i) begin
                    beat_s      = beat_r - 9'd1;
                    remain_s    = remain_dec_s;
                    burst_err_s = burst_err_r | (w_last_i != beat_last_s);
                    // The AW length, not w_last, decides where the burst ends.
                    if (beat_last_s) begin
                        state_s = RESP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            RESP: begin
                b_valid_o = 1'b1;
                b_id_o    = bid_r;
                b_resp_o  = burst_err_r ? RespSlverr : RespOkay;
                if (b_ready_i) begin
                    err_s = err_r | burst_err_r;
                    if (remain_r == {LenWidth{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = WAIT_AW;
                    end
                end else begin
                    state_s = RESP;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: doc/xdma_burst_collector.md
XDMA_BURST_COLLECTOR -- requirements
Module: xdma_burst_collector

Interface
REQ-001 SHALL have parameter DataWidth, default 512, meaning W/data-out width in bits.
REQ-002 SHALL have parameter LenWidth, default 32, meaning width of dma_length (units: beats).
REQ-003 SHALL have parameter IdWidth, default 4, meaning AXI ID width.
REQ-004 SHALL have parameter MaxNumBeats, default 64, meaning largest legal burst (aw_len+1).
REQ-005 clk_i  in  1  clock; all state changes on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 desc_valid_i / desc_ready_o  in/out  1/1  expected-transfer descriptor handshake.
REQ-008 desc_len_i  in  LenWidth  total beats expected for the transfer.
REQ-009 desc_id_i  in  IdWidth  expected AXI ID of the transfer.
REQ-010 aw_valid_i / aw_ready_o  in/out  1/1  AW handshake.
REQ-011 aw_id_i  in  IdWidth; aw_len_i  in  8  burst length minus 1.
REQ-012 w_valid_i / w_ready_o  in/out  1/1  W handshake.
REQ-013 w_data_i  in  DataWidth; w_last_i  in  1  last beat of burst.
REQ-014 data_valid_o / data_ready_i  out/in  1/1  collected-data stream handshake.
REQ-015 data_o  out  DataWidth  collected beat.
REQ-016 b_valid_o / b_ready_i  out/in  1/1  B handshake.
REQ-017 b_id_o  out  IdWidth; b_resp_o  out  2  OKAY 2'b00 / SLVERR 2'b10.
REQ-018 done_o  out  1  one-cycle pulse at transfer completion.
REQ-019 err_o  out  1  sticky error flag for current transfer.

Function
REQ-020 States SHALL be IDLE, WAIT_AW, DATA, RESP, DONE.
REQ-021 IDLE: desc_ready_o=1; on desc handshake load remain_q=desc_len_i, exp_id_q=desc_id_i, clear err_o; go WAIT_AW, or DONE if desc_len_i==0.
REQ-022 WAIT_AW: aw_ready_o=1; on AW handshake load beat_q=aw_len_i+1 (9-bit), bid_q=aw_id_i, burst_err_q=0; go DATA.
REQ-023 AW check: burst_err_q SHALL set at AW handshake if aw_id_i!=exp_id_q, aw_len_i+1>MaxNumBeats, or aw_len_i+1>remain_q.
REQ-024 DATA: data_valid_o=w_valid_i, w_ready_o=data_ready_i, data_o=w_data_i, combinational pass-through, zero latency.
REQ-025 Each W handshake SHALL decrement beat_q by 1 and remain_q by 1; remain_q SHALL saturate at 0, never wrap.
REQ-026 w_last_i SHALL be checked each beat: mismatch with (beat_q==1) sets burst_err_q.
REQ-027 Burst SHALL end on the beat where beat_q==1, regardless of w_last_i; go RESP.
REQ-028 RESP: b_valid_o=1, b_id_o=bid_q, b_resp_o=SLVERR if burst_err_q else OKAY; b_valid_o held until b_ready_i.
REQ-029 On B handshake: err_o|=burst_err_q; go DONE if remain_q==0 else WAIT_AW.
REQ-030 DONE: done_o=1 for exactly one cycle; go IDLE; err_o holds until next descriptor accepted.
REQ-031 aw_ready_o, w_ready_o, desc_ready_o SHALL be 0 outside their own states; no AW accepted before B of prior burst completes.
REQ-032 Outputs SHALL not depend combinationally on their own ready inputs except the REQ-024 pass-through.

Reset
REQ-033 On rst_ni low: state=IDLE, remain_q=0, beat_q=0, err_o=0, done_o=0, b_valid_o=0, aw_ready_o=0, w_ready_o=0, data_valid_o=0, b_resp_o=0, b_id_o=0; desc_ready_o=1 after release.
REQ-034 Reset mid-transfer SHALL abandon the transfer with no B or done_o emitted.

Verification
REQ-035 desc_len=64, one AW len=63, 64 beats with last on beat 64 -> 64 data_o beats, one B OKAY, done_o pulse, err_o=0.
REQ-036 desc_len=130, AWs len 63/63/1 -> three B OKAY in order, remain_q reaches 0, single done_o after third B.
REQ-037 desc_len=4, AW len=3, w_last on beat 2 -> burst still ends after beat 4, B SLVERR, err_o=1 after done_o.
REQ-038 desc_len=8, AW len=15 -> SLVERR; remain_q saturates at 0; done_o after B.
REQ-039 data_ready_i toggled low every other cycle, b_ready_i low 5 cycles -> no beat lost or duplicated, b_valid_o stable until accepted.
REQ-040 rst_ni asserted during DATA of beat 10 of 64 -> all outputs at reset values; next descriptor len=2 completes normally.
